// File: rtl/adder_ctrl_pkg.sv
// Shared FSM encodings, requester ids and the full-adder cell used by the shared adder.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/ripple_adder_n.sv
// WIDTH-bit ripple-carry adder built from full-adder cells, carry_in tied low.
// Purely combinational; the carry chain is treated as a multicycle path by its user.
module ripple_adder_n
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] fa;
    assign fa         = full_add(a_i[i], b_i[i], carry[i]);
    assign sum_o[i]   = fa[0];
    assign carry[i+1] = fa[1];
  end

  assign carry_o = carry[WIDTH];

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one ripple adder between two requesters; operands held
// ADD_CYCLES clocks before capture, result returned on a valid/ready port.
module adder_share_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_id_q, op_id_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic             gnt_vld;
  logic             gnt_id;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  ripple_adder_n #(.WIDTH(WIDTH)) u_adder (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // Ready is suppressed while rst is high so a held valid is never seen as accepted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = ID_REQ0;
    if (state_q == S_IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_REQ0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_REQ1;
      end
    end
  end

  assign req0_ready = gnt_vld && (gnt_id == ID_REQ0);
  assign req1_ready = gnt_vld && (gnt_id == ID_REQ1);
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_carry_d  = rsp_carry_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          op_a_d       = (gnt_id == ID_REQ1) ? req1_a : req0_a;
          op_b_d       = (gnt_id == ID_REQ1) ? req1_b : req0_b;
          op_id_d      = gnt_id;
          last_grant_d = gnt_id;
          cnt_d        = CW'(ADD_CYCLES - 1);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_sum_d   = add_sum;
          rsp_carry_d = add_carry;
          rsp_id_d    = op_id_q;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= ID_REQ0;
      last_grant_q <= ID_REQ1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= ID_REQ0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench: u2 runs with ADD_CYCLES=2, u4 with ADD_CYCLES=4 for the abort case.
module tb_adder_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst2, r0v2, r1v2, rrdy2;
  logic [7:0] r0a2, r0b2, r1a2, r1b2;
  logic       r0rdy2, r1rdy2, rv2, rid2, rc2, busy2;
  logic [7:0] rs2;

  logic       rst4, r0v4, r1v4, rrdy4;
  logic [7:0] r0a4, r0b4, r1a4, r1b4;
  logic       r0rdy4, r1rdy4, rv4, rid4, rc4, busy4;
  logic [7:0] rs4;

  adder_share_arbiter #(.WIDTH(8), .ADD_CYCLES(2)) u2 (
    .clk(clk), .rst(rst2),
    .req0_valid(r0v2), .req0_a(r0a2), .req0_b(r0b2), .req0_ready(r0rdy2),
    .req1_valid(r1v2), .req1_a(r1a2), .req1_b(r1b2), .req1_ready(r1rdy2),
    .rsp_valid(rv2), .rsp_id(rid2), .rsp_sum(rs2), .rsp_carry(rc2),
    .rsp_ready(rrdy2), .busy(busy2)
  );

  adder_share_arbiter #(.WIDTH(8), .ADD_CYCLES(4)) u4 (
    .clk(clk), .rst(rst4),
    .req0_valid(r0v4), .req0_a(r0a4), .req0_b(r0b4), .req0_ready(r0rdy4),
    .req1_valid(r1v4), .req1_a(r1a4), .req1_b(r1b4), .req1_ready(r1rdy4),
    .rsp_valid(rv4), .rsp_id(rid4), .rsp_sum(rs4), .rsp_carry(rc4),
    .rsp_ready(rrdy4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_id;
    logic [7:0] exp_sum;
    logic exp_c;

    rst2 = 1'b1; rrdy2 = 1'b0;
    r0v2 = 1'b1; r0a2 = 8'h12; r0b2 = 8'h34;
    r1v2 = 1'b1; r1a2 = 8'hFF; r1b2 = 8'h01;
    rst4 = 1'b1; rrdy4 = 1'b0;
    r0v4 = 1'b0; r0a4 = 8'h05; r0b4 = 8'h07;
    r1v4 = 1'b0; r1a4 = 8'h20; r1b4 = 8'h22;

    // 1: reset with both valids high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready0", {31'd0, r0rdy2}, 32'd0);
      chk("rst_ready1", {31'd0, r1rdy2}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rv2}, 32'd0);
      chk("rst_busy", {31'd0, busy2}, 32'd0);
    end
    chk("rst_sum", {24'd0, rs2}, 32'd0);
    rst2 = 1'b0; rst4 = 1'b0;
    #1;
    chk("first_tie_ready0", {31'd0, r0rdy2}, 32'd1);
    chk("first_tie_ready1", {31'd0, r1rdy2}, 32'd0);

    // 2: single op 0x12+0x34, accepted on this edge
    tick();
    r0v2 = 1'b0; r1v2 = 1'b0;
    #1;
    chk("wait_busy", {31'd0, busy2}, 32'd1);
    chk("wait_ready0", {31'd0, r0rdy2}, 32'd0);
    chk("wait_rv_e1", {31'd0, rv2}, 32'd0);
    tick();
    chk("wait_rv_e2", {31'd0, rv2}, 32'd0);
    tick();
    chk("op1_valid", {31'd0, rv2}, 32'd1);
    chk("op1_sum", {24'd0, rs2}, 32'h46);
    chk("op1_carry", {31'd0, rc2}, 32'd0);
    chk("op1_id", {31'd0, rid2}, 32'd0);

    // 5: backpressure in DONE with req1 waiting
    r1v2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, rv2}, 32'd1);
      chk("bp_sum", {24'd0, rs2}, 32'h46);
      chk("bp_id", {31'd0, rid2}, 32'd0);
      chk("bp_busy", {31'd0, busy2}, 32'd1);
      chk("bp_ready1", {31'd0, r1rdy2}, 32'd0);
    end
    rrdy2 = 1'b1;
    #1;
    chk("done_simul_ready1", {31'd0, r1rdy2}, 32'd0);
    tick();
    rrdy2 = 1'b0;
    #1;
    chk("rsp_drop", {31'd0, rv2}, 32'd0);
    chk("idle_busy", {31'd0, busy2}, 32'd0);
    chk("next_grant_ready1", {31'd0, r1rdy2}, 32'd1);

    // 3: overflow 0xFF+0x01 from req1
    tick();
    r1v2 = 1'b0;
    tick();
    tick();
    chk("ovf1_valid", {31'd0, rv2}, 32'd1);
    chk("ovf1_sum", {24'd0, rs2}, 32'h00);
    chk("ovf1_carry", {31'd0, rc2}, 32'd1);
    chk("ovf1_id", {31'd0, rid2}, 32'd1);
    rrdy2 = 1'b1;
    tick();
    rrdy2 = 1'b0;
    r0v2 = 1'b1; r0a2 = 8'hFF; r0b2 = 8'hFF;
    #1;
    chk("ovf2_ready0", {31'd0, r0rdy2}, 32'd1);
    tick();
    r0v2 = 1'b0;
    tick();
    tick();
    chk("ovf2_sum", {24'd0, rs2}, 32'hFE);
    chk("ovf2_carry", {31'd0, rc2}, 32'd1);
    chk("ovf2_id", {31'd0, rid2}, 32'd0);
    rrdy2 = 1'b1;
    tick();

    // 4: fairness, last grant was req0 so req1 goes first
    r0a2 = 8'h10; r0b2 = 8'h20;
    r1a2 = 8'h80; r1b2 = 8'h90;
    r0v2 = 1'b1; r1v2 = 1'b1;
    exp_id = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_sum = exp_id ? 8'h10 : 8'h30;
      exp_c   = exp_id;
      #1;
      chk("fair_ready0", {31'd0, r0rdy2}, {31'd0, ~exp_id});
      chk("fair_ready1", {31'd0, r1rdy2}, {31'd0, exp_id});
      tick();
      chk("fair_noready", {30'd0, r0rdy2, r1rdy2}, 32'd0);
      tick();
      tick();
      chk("fair_valid", {31'd0, rv2}, 32'd1);
      chk("fair_id", {31'd0, rid2}, {31'd0, exp_id});
      chk("fair_sum", {24'd0, rs2}, {24'd0, exp_sum});
      chk("fair_carry", {31'd0, rc2}, {31'd0, exp_c});
      tick();
      exp_id = ~exp_id;
    end
    r0v2 = 1'b0; r1v2 = 1'b0;

    // 6: abort during WAIT with ADD_CYCLES=4
    rrdy4 = 1'b1;
    r0v4 = 1'b1;
    #1;
    chk("abort_ready0", {31'd0, r0rdy4}, 32'd1);
    tick();
    r0v4 = 1'b0;
    tick();
    chk("abort_busy_wait", {31'd0, busy4}, 32'd1);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    #1;
    chk("abort_rv", {31'd0, rv4}, 32'd0);
    chk("abort_busy", {31'd0, busy4}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_rsp", {31'd0, rv4}, 32'd0);
    end
    rrdy4 = 1'b0;
    r1v4 = 1'b1;
    #1;
    chk("post_abort_ready1", {31'd0, r1rdy4}, 32'd1);
    tick();
    r1v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_abort_wait", {31'd0, rv4}, 32'd0);
    end
    tick();
    chk("post_abort_valid", {31'd0, rv4}, 32'd1);
    chk("post_abort_sum", {24'd0, rs4}, 32'h42);
    chk("post_abort_carry", {31'd0, rc4}, 32'd0);
    chk("post_abort_id", {31'd0, rid4}, 32'd1);
    rrdy4 = 1'b1;
    tick();
    chk("post_abort_drop", {31'd0, rv4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
